// File: rtl/pulse_param_bank_pkg.sv
// pulse_bank_pkg: register indices, reset defaults, control-byte layout, reply codes and checksum helper
package pulse_bank_pkg;
  localparam int REG_DELAY = 0;
  localparam int REG_PERIOD = 1;
  localparam int REG_P1WIDTH = 2;
  localparam int REG_P2WIDTH = 3;
  localparam logic [63:0] DEF_DELAY = 64'd200;
  localparam logic [63:0] DEF_PERIOD = 64'd200000;
  localparam logic [63:0] DEF_P1WIDTH = 64'd30;
  localparam logic [63:0] DEF_P2WIDTH = 64'd30;
  localparam int CTRL_RD_BIT = 7;
  localparam logic [7:0] REPLY_BADADDR = 8'hFF;
  function automatic logic [63:0] reg_default(input int i);
    return i == REG_DELAY ? DEF_DELAY : i == REG_PERIOD ? DEF_PERIOD :
           i == REG_P1WIDTH ? DEF_P1WIDTH : i == REG_P2WIDTH ? DEF_P2WIDTH : 64'd0;
  endfunction
  function automatic logic [7:0] byte_sum(input logic [63:0] v, input int nb);
    logic [7:0] s;
    s = '0;
    for (int k = 0; k < 8; k++) if (k < nb) s = s + v[k*8 +: 8];
    return s;
  endfunction
endpackage

// File: rtl/pulse_param_bank_if.sv
// pulse_param_bank_if: UART byte link (rx_byte/rx_valid in, tx_byte/tx_start out, tx_busy back-pressure)
interface pulse_param_bank_if;
  logic [7:0] rx_byte;
  logic rx_valid;
  logic [7:0] tx_byte;
  logic tx_start;
  logic tx_busy;
  modport master(output rx_byte, rx_valid, tx_busy, input tx_byte, tx_start);
  modport slave(input rx_byte, rx_valid, tx_busy, output tx_byte, tx_start);
endinterface

// File: rtl/pulse_param_bank_frame_rx.sv
// pulse_frame_rx: assembles DW/8 LSB-first data bytes plus a control byte into frame_valid/data/ctrl; timeout aborts a stalled partial frame
module pulse_frame_rx #(
  parameter int DW = 32,
  parameter int TIMEOUT = 120000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [7:0]    rx_byte,
  input  logic          rx_valid,
  output logic          frame_valid,
  output logic [DW-1:0] data,
  output logic [7:0]    ctrl,
  output logic          timeout
);
  localparam int NB = DW / 8;
  localparam int CW = $clog2(NB + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  logic [TW-1:0] idle;
  logic take;
  assign take = en && rx_valid;
  assign frame_valid = take && cnt == CW'(NB);
  assign ctrl = rx_byte;
  assign timeout = cnt != 0 && !rx_valid && idle == TW'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      idle <= '0;
      data <= '0;
    end else begin
      idle <= (rx_valid || cnt == 0) ? '0 : idle + 1'b1;
      if (timeout || frame_valid) cnt <= '0;
      else if (take) begin
        data[cnt*8 +: 8] <= rx_byte;
        cnt <= cnt + 1'b1;
      end
    end
endmodule

// File: rtl/pulse_param_bank.sv
// pulse_param_bank: UART-framed shadow/active register bank (clk, rst_n, uart link, period_tick in; par, p2start/sync_up/att_down, pending, frame_err out)
module pulse_param_bank
  import pulse_bank_pkg::*;
#(
  parameter int DW = 32,
  parameter int NREG = 8,
  parameter int ATT_DELAY = 20000,
  parameter int TIMEOUT = 120000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pulse_param_bank_if.slave    uart,
  input  logic                 period_tick,
  output logic [NREG*DW-1:0]   par,
  output logic [DW-1:0]        p2start,
  output logic [DW-1:0]        sync_up,
  output logic [DW-1:0]        att_down,
  output logic                 pending,
  output logic                 frame_err
);
  localparam int NB = DW / 8;
  localparam int RW = DW + 8;
  localparam int AW = $clog2(NREG);
  localparam logic [1:0] S_RX = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_TX_REQ = 2'd2;
  localparam logic [1:0] S_TX_WAIT = 2'd3;
  logic [1:0] state;
  logic [DW-1:0] shadow [NREG];
  logic [DW-1:0] active [NREG];
  logic [DW-1:0] fr_data, ex_data, rd_val;
  logic [7:0] fr_ctrl, ex_ctrl;
  logic fr_valid, fr_tout, ex_ok, ex_rd, ex_wr, seen;
  logic [AW-1:0] ex_idx;
  logic [RW-1:0] rbuf;
  logic [3:0] rem;
  pulse_frame_rx #(.DW(DW), .TIMEOUT(TIMEOUT)) u_rx (
    .clk(clk),
    .rst_n(rst_n),
    .en(state == S_RX),
    .rx_byte(uart.rx_byte),
    .rx_valid(uart.rx_valid),
    .frame_valid(fr_valid),
    .data(fr_data),
    .ctrl(fr_ctrl),
    .timeout(fr_tout)
  );
  assign ex_ok = int'(ex_ctrl[6:0]) < NREG;
  assign ex_rd = ex_ctrl[CTRL_RD_BIT];
  assign ex_idx = ex_ctrl[AW-1:0];
  assign ex_wr = state == S_EXEC && !ex_rd && ex_ok;
  assign rd_val = active[ex_idx];
  assign uart.tx_byte = rbuf[7:0];
  assign uart.tx_start = state == S_TX_REQ && !uart.tx_busy;
  for (genvar i = 0; i < NREG; i++) begin : g_par
    assign par[i*DW +: DW] = active[i];
  end
  // A tick copies the pre-write shadow; a write in the same cycle keeps pending for the next tick.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        shadow[i] <= DW'(reg_default(i));
        active[i] <= DW'(reg_default(i));
      end
      pending <= 1'b0;
    end else begin
      if (period_tick && pending) for (int i = 0; i < NREG; i++) active[i] <= shadow[i];
      if (ex_wr) shadow[ex_idx] <= ex_data;
      pending <= ex_wr | (pending & ~period_tick);
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      p2start <= DW'(DEF_P1WIDTH + DEF_DELAY);
      sync_up <= DW'(DEF_P1WIDTH + DEF_DELAY + DEF_P2WIDTH);
      att_down <= DW'(DEF_P1WIDTH + DEF_DELAY + DEF_P2WIDTH + 64'(ATT_DELAY));
    end else begin
      p2start <= active[REG_P1WIDTH] + active[REG_DELAY];
      sync_up <= p2start + active[REG_P2WIDTH];
      att_down <= sync_up + DW'(ATT_DELAY);
    end
  // Reply bytes sit LSB-first in rbuf; each completed UART transfer shifts the next one down.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_RX;
      ex_data <= '0;
      ex_ctrl <= '0;
      rbuf <= '0;
      rem <= '0;
      seen <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= fr_tout | (uart.rx_valid && state != S_RX) | (state == S_EXEC && !ex_ok);
      case (state)
        S_RX:
          if (fr_valid) begin
            ex_data <= fr_data;
            ex_ctrl <= fr_ctrl;
            state <= S_EXEC;
          end
        S_EXEC: begin
          rbuf <= !ex_ok ? RW'(REPLY_BADADDR) :
                  ex_rd ? {byte_sum(64'(rd_val), NB), rd_val} : RW'(byte_sum(64'(ex_data), NB));
          rem <= ex_ok && ex_rd ? 4'(NB + 1) : 4'd1;
          state <= S_TX_REQ;
        end
        S_TX_REQ:
          if (!uart.tx_busy) begin
            seen <= 1'b0;
            state <= S_TX_WAIT;
          end
        S_TX_WAIT:
          if (uart.tx_busy) seen <= 1'b1;
          else if (seen) begin
            if (rem > 4'd1) begin
              rbuf <= rbuf >> 8;
              rem <= rem - 4'd1;
              state <= S_TX_REQ;
            end else state <= S_RX;
          end
      endcase
    end
endmodule

// File: tb/tb_pulse_param_bank.sv
// tb_pulse_param_bank: randomized frames against a shadow/active array model with a UART busy responder
module tb_pulse_param_bank;
  localparam int DW = 32;
  localparam int NREG = 8;
  localparam int ATT = 20000;
  localparam int TO = 300;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic period_tick = 1'b0;
  logic [NREG*DW-1:0] par;
  logic [DW-1:0] p2start, sync_up, att_down;
  logic pending, frame_err;
  pulse_param_bank_if u();
  pulse_param_bank #(.DW(DW), .NREG(NREG), .ATT_DELAY(ATT), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .uart(u), .period_tick(period_tick), .par(par),
    .p2start(p2start), .sync_up(sync_up), .att_down(att_down), .pending(pending), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  int n_tests = 0;
  int n_fail = 0;
  int n_ferr = 0;
  int n_txs = 0;
  logic [7:0] txq [$];
  logic uart_idle = 1'b1;
  logic [31:0] m_shadow [NREG];
  logic [31:0] m_active [NREG];
  logic m_pending;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] sum8(input logic [31:0] d);
    int s;
    s = 0;
    for (int k = 0; k < 4; k++) s += int'((d >> (8 * k)) & 32'hFF);
    return 8'(s % 256);
  endfunction
  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_active[i] = 0;
    m_active[0] = 200;
    m_active[1] = 200000;
    m_active[2] = 30;
    m_active[3] = 30;
    for (int i = 0; i < NREG; i++) m_shadow[i] = m_active[i];
    m_pending = 1'b0;
  endtask
  task automatic model_tick();
    if (m_pending) begin
      for (int i = 0; i < NREG; i++) m_active[i] = m_shadow[i];
      m_pending = 1'b0;
    end
  endtask
  task automatic check_state();
    logic [31:0] p2, sy, at;
    for (int i = 0; i < NREG; i++) check($sformatf("par%0d", i), par[i*DW +: DW], m_active[i]);
    check("pending", pending, m_pending);
    p2 = m_active[2] + m_active[0];
    sy = p2 + m_active[3];
    at = sy + ATT;
    check("p2start", p2start, p2);
    check("sync_up", sync_up, sy);
    check("att_down", att_down, at);
  endtask
  initial begin
    u.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (u.tx_start) begin
        txq.push_back(u.tx_byte);
        n_txs++;
        uart_idle = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge clk);
        u.tx_busy = 1'b1;
        repeat ($urandom_range(1, 5)) @(negedge clk);
        u.tx_busy = 1'b0;
        uart_idle = 1'b1;
      end
    end
  end
  always @(negedge clk) if (frame_err) n_ferr++;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    u.rx_byte = b;
    u.rx_valid = 1'b1;
    @(negedge clk);
    u.rx_valid = 1'b0;
  endtask
  task automatic wait_bytes(input int n);
    int t;
    t = 0;
    while ((txq.size() < n || !uart_idle) && t < 500) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
  endtask
  task automatic do_frame(input logic [31:0] d, input logic [7:0] c, input logic tk, input logic inj);
    logic [7:0] exp [$];
    int a, fe0, t;
    logic ok;
    a = int'(c[6:0]);
    ok = a < NREG;
    fe0 = n_ferr;
    if (!ok) exp.push_back(8'hFF);
    else if (c[7]) begin
      for (int k = 0; k < 4; k++) exp.push_back(8'(m_active[a] >> (8 * k)));
      exp.push_back(sum8(m_active[a]));
    end else exp.push_back(sum8(d));
    if (tk) model_tick();
    if (ok && !c[7]) begin
      m_shadow[a] = d;
      m_pending = 1'b1;
    end
    for (int k = 0; k < 4; k++) send_byte(d[k*8 +: 8]);
    @(negedge clk);
    u.rx_byte = c;
    u.rx_valid = 1'b1;
    @(negedge clk);
    u.rx_valid = 1'b0;
    period_tick = tk;
    @(negedge clk);
    period_tick = 1'b0;
    if (inj) begin
      t = 0;
      while (txq.size() < 1 && t < 200) begin
        @(negedge clk);
        t++;
      end
      send_byte(8'hA5);
    end
    wait_bytes(exp.size());
    check($sformatf("reply_len c=%0h", c), txq.size(), exp.size());
    for (int k = 0; k < exp.size(); k++)
      check($sformatf("reply%0d c=%0h", k, c), k < txq.size() ? 64'(txq[k]) : 64'hBAD, exp[k]);
    txq.delete();
    check($sformatf("frame_err c=%0h", c), n_ferr - fe0, (ok ? 0 : 1) + (inj ? 1 : 0));
    repeat (4) @(negedge clk);
    check_state();
  endtask
  task automatic tick();
    @(negedge clk);
    period_tick = 1'b1;
    @(negedge clk);
    period_tick = 1'b0;
    model_tick();
    repeat (5) @(negedge clk);
    check_state();
  endtask
  initial begin
    int fe0, n0, op, t;
    logic [6:0] a;
    logic [31:0] d;
    u.rx_byte = 8'h00;
    u.rx_valid = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_tx_start", u.tx_start, 0);
    check("rst_tx_byte", u.tx_byte, 0);
    check("rst_frame_err", frame_err, 0);
    check_state();
    rst_n = 1'b1;
    @(negedge clk);
    do_frame(32'h0, 8'h81, 1'b0, 1'b0);
    do_frame(32'h64, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    period_tick = 1'b1;
    @(negedge clk);
    period_tick = 1'b0;
    model_tick();
    check("delay_applied", par[31:0], 100);
    check("pending_clr", pending, 0);
    check("p2start_old", p2start, 230);
    @(negedge clk);
    check("p2start_new", p2start, 130);
    check("sync_up_old", sync_up, 260);
    @(negedge clk);
    check("sync_up_new", sync_up, 160);
    check("att_down_old", att_down, 20260);
    @(negedge clk);
    check("att_down_new", att_down, 20160);
    do_frame(32'd150000, 8'h01, 1'b0, 1'b0);
    do_frame(32'd55, 8'h03, 1'b1, 1'b0);
    tick();
    fe0 = n_ferr;
    n0 = n_txs;
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (TO - 5) @(negedge clk);
    check("no_early_timeout", n_ferr - fe0, 0);
    repeat (15) @(negedge clk);
    check("timeout_err", n_ferr - fe0, 1);
    check("timeout_no_tx", n_txs - n0, 0);
    do_frame(32'd40, 8'h02, 1'b0, 1'b0);
    tick();
    do_frame(32'h12345678, 8'h7F, 1'b0, 1'b0);
    do_frame(32'h0, 8'h82, 1'b0, 1'b1);
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 7);
      a = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(NREG, 127)) : 7'($urandom_range(0, NREG - 1));
      d = $urandom;
      if (op < 3) do_frame(d, {1'b0, a}, 1'b0, 1'b0);
      else if (op < 5) do_frame(d, {1'b1, a}, 1'b0, 1'b0);
      else if (op == 5) tick();
      else if (op == 6) do_frame(d, {1'b0, a}, 1'b1, 1'b0);
      else do_frame(d, {1'b1, a}, 1'b0, int'(a) < NREG);
    end
    do_frame(32'hDEADBEEF, 8'h05, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) send_byte(8'h00);
    send_byte(8'h81);
    t = 0;
    while (txq.size() < 2 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("pre_rst_bytes", txq.size() >= 2, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx_start", u.tx_start, 0);
    check("mid_rst_tx_byte", u.tx_byte, 0);
    model_reset();
    n0 = n_txs;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("no_tx_after_rst", n_txs - n0, 0);
    check_state();
    txq.delete();
    do_frame(32'h0, 8'h81, 1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
